// File: rtl/bomb_timer_pkg.sv
// Shared types and helpers for the bomb game countdown timer.
//   timer_state_e   : controller states
//   bcd_digit_t     : one BCD digit
//   bin_to_bcd      : double-dabble binary to BCD conversion over num_digits digits
//   PENALTY_BCD     : default strike penalty, already in BCD
package bomb_timer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StPaused,
        StExpired,
        StDefused
    } timer_state_e;

    typedef logic [3:0] bcd_digit_t;

    // Enough digits for any 32-bit value.
    localparam int unsigned MAX_DIGITS      = 10;
    localparam int unsigned DEF_PENALTY_SEC = 10;

    // Only the low num_digits digits are corrected; callers saturate the input so that
    // the value always fits in num_digits digits.
    function automatic logic [4*MAX_DIGITS-1:0] bin_to_bcd(input logic [31:0] bin,
                                                            input int unsigned num_digits);
        logic [4*MAX_DIGITS-1:0] bcd;
        bcd = '0;
        for (int i = 31; i >= 0; i--) begin
            for (int d = 0; d < MAX_DIGITS; d++) begin
                if (d < num_digits && bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[4*MAX_DIGITS-2:0], bin[i]};
        end
        return bcd;
    endfunction

    localparam logic [4*MAX_DIGITS-1:0] PENALTY_BCD = bin_to_bcd(DEF_PENALTY_SEC, MAX_DIGITS);

endpackage

// File: rtl/bcd_sub_sat.sv
// Combinational NUM_DIGITS-wide BCD subtractor, a_i - b_i, saturating at zero.
//   a_i    : minuend (BCD)
//   b_i    : subtrahend (BCD)
//   diff_o : difference, forced to 0 on final borrow
//   zero_o : diff_o is zero
module bcd_sub_sat
    import bomb_timer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 3
) (
    input  logic [4*NUM_DIGITS-1:0] a_i,
    input  logic [4*NUM_DIGITS-1:0] b_i,
    output logic [4*NUM_DIGITS-1:0] diff_o,
    output logic                    zero_o
);

    logic [4*NUM_DIGITS-1:0] raw;
    logic [NUM_DIGITS:0]     borrow;
    logic [4:0]              t;
    bcd_digit_t              a_dig;
    bcd_digit_t              b_dig;

    always_comb begin
        raw    = '0;
        borrow = '0;
        t      = '0;
        a_dig  = '0;
        b_dig  = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            a_dig = a_i[4*d +: 4];
            b_dig = b_i[4*d +: 4];
            // Range -10..9 fits a 5-bit two's complement value; bit 4 flags a borrow.
            t = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, borrow[d]};
            if (t[4]) begin
                raw[4*d +: 4] = t[3:0] + 4'd10;
                borrow[d+1]   = 1'b1;
            end else begin
                raw[4*d +: 4] = t[3:0];
                borrow[d+1]   = 1'b0;
            end
        end
        diff_o = borrow[NUM_DIGITS] ? '0 : raw;
        zero_o = (diff_o == '0);
    end

endmodule

// File: rtl/bomb_countdown_timer.sv
// Bomb game countdown timer. Loads a per-level start time, counts down once per second
// in BCD, takes a penalty per strike, and ends as expired (time out) or defused.
//   clk, reset  : clock, synchronous active-high reset
//   game_level  : level, sampled on start
//   start       : pulse, load level time and run (ignored while running/paused)
//   pause       : level, hold countdown
//   strike      : pulse, subtract PENALTY_SEC
//   defuse      : pulse, stop as a win
//   digits      : BCD remaining seconds, MSD in top nibble
//   running / expired / defused : state flags
//   sec_tick    : pulse on each one-second decrement
//   warn        : low-time warning; only generated when BOMB_TIMER_WARN_EN is defined
module bomb_countdown_timer
    import bomb_timer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 3,
    parameter int unsigned LEVEL_W     = 8,
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned BASE_SEC    = 300,
    parameter int unsigned STEP_SEC    = 20,
    parameter int unsigned MIN_SEC     = 30,
    parameter int unsigned PENALTY_SEC = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LEVEL_W-1:0]      game_level,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    strike,
    input  logic                    defuse,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    expired,
    output logic                    defused,
    output logic                    sec_tick,
    output logic                    warn
);

    localparam int unsigned DW       = 4 * NUM_DIGITS;
    localparam int unsigned PRESC_W  = $clog2(TICK_DIV);
    localparam int unsigned MAX_SEC  = 10 ** NUM_DIGITS - 1;
    localparam int unsigned PEN_SAT  = (PENALTY_SEC > MAX_SEC) ? MAX_SEC : PENALTY_SEC;
    localparam int unsigned PEN1_SAT = (PENALTY_SEC >= MAX_SEC) ? MAX_SEC : PENALTY_SEC + 1;

    localparam logic [DW-1:0] PEN_BCD =
        (PENALTY_SEC == DEF_PENALTY_SEC && NUM_DIGITS >= 2) ? DW'(PENALTY_BCD)
                                                             : DW'(bin_to_bcd(PEN_SAT, NUM_DIGITS));
    localparam logic [DW-1:0] PEN1_BCD = DW'(bin_to_bcd(PEN1_SAT, NUM_DIGITS));
    localparam logic [DW-1:0] ONE_BCD  = DW'(1);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    timer_state_e        state_q, state_d;
    logic [DW-1:0]       digits_q, digits_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic                tick_q, tick_d;

    // Start time from the captured level, clamped to MIN_SEC then to the display range.
    longint              lvl_time;
    logic [31:0]         start_sec;
    logic [DW-1:0]       start_bcd;

    always_comb begin
        lvl_time = longint'(BASE_SEC) - longint'(level_q) * longint'(STEP_SEC);
        if (lvl_time < longint'(MIN_SEC)) lvl_time = longint'(MIN_SEC);
        if (lvl_time > longint'(MAX_SEC)) lvl_time = longint'(MAX_SEC);
        start_sec = 32'(lvl_time);
        start_bcd = DW'(bin_to_bcd(start_sec, NUM_DIGITS));
    end

    // Countdown event decode; everything here is ahead of the defuse priority in the FSM.
    logic          counting;
    logic          tick_now;
    logic [DW-1:0] sub_b;
    logic [DW-1:0] sub_diff;
    logic          sub_zero;

    assign counting = (state_q == StRun) && !pause;
    assign tick_now = counting && (presc_q == PRESC_MAX);

    always_comb begin
        sub_b = ONE_BCD;
        if (tick_now && strike) begin
            sub_b = PEN1_BCD;
        end else if (strike) begin
            sub_b = PEN_BCD;
        end
    end

    bcd_sub_sat #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_sub (
        .a_i    (digits_q),
        .b_i    (sub_b),
        .diff_o (sub_diff),
        .zero_o (sub_zero)
    );

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        presc_d  = presc_q;
        level_d  = level_q;
        tick_d   = 1'b0;
        unique case (state_q)
            StIdle, StExpired, StDefused: begin
                if (start) begin
                    state_d = StLoad;
                    level_d = game_level;
                end
            end
            StLoad: begin
                digits_d = start_bcd;
                presc_d  = '0;
                state_d  = (start_bcd == '0) ? StExpired : StRun;
            end
            StRun, StPaused: begin
                if (defuse) begin
                    state_d = StDefused;
                end else begin
                    if (counting) begin
                        presc_d = tick_now ? '0 : presc_q + 1'b1;
                    end
                    state_d = pause ? StPaused : StRun;
                    if (tick_now || strike) begin
                        digits_d = sub_diff;
                        tick_d   = tick_now;
                        if (sub_zero) state_d = StExpired;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            digits_q <= '0;
            presc_q  <= '0;
            level_q  <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            presc_q  <= presc_d;
            level_q  <= level_d;
            tick_q   <= tick_d;
        end
    end

    assign digits   = digits_q;
    assign running  = (state_q == StRun);
    assign expired  = (state_q == StExpired);
    assign defused  = (state_q == StDefused);
    assign sec_tick = tick_q;

`ifdef BOMB_TIMER_WARN_EN
    localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(TICK_DIV / 2);
    logic below_ten;
    assign below_ten = ((digits_q >> 4) == '0);
    // Steady while paused, blinking at 1 Hz while running.
    assign warn = below_ten &&
                  ((state_q == StPaused) || ((state_q == StRun) && (presc_q < PRESC_HALF)));
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_bomb_countdown_timer.sv
module tb_bomb_countdown_timer;

    localparam int unsigned TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  game_level;
    logic        start;
    logic        pause;
    logic        strike;
    logic        defuse;
    logic [11:0] digits;
    logic        running;
    logic        expired;
    logic        defused;
    logic        sec_tick;
    logic        warn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bomb_countdown_timer #(
        .NUM_DIGITS  (3),
        .LEVEL_W     (8),
        .TICK_DIV    (TICK_DIV),
        .BASE_SEC    (300),
        .STEP_SEC    (20),
        .MIN_SEC     (30),
        .PENALTY_SEC (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .game_level (game_level),
        .start      (start),
        .pause      (pause),
        .strike     (strike),
        .defuse     (defuse),
        .digits     (digits),
        .running    (running),
        .expired    (expired),
        .defused    (defused),
        .sec_tick   (sec_tick),
        .warn       (warn)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active edge, then return at the following falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_digits(input string tag, input logic [11:0] target);
        int n = 0;
        while (digits !== target && n < 2000) begin
            step();
            n++;
        end
        check_eq(tag, 32'(digits), 32'(target));
    endtask

    task automatic start_level(input logic [7:0] lvl);
        game_level = lvl;
        start      = 1'b1;
        step();
        start      = 1'b0;
        step();
    endtask

    initial begin
        reset      = 1'b1;
        game_level = '0;
        start      = 1'b0;
        pause      = 1'b0;
        strike     = 1'b0;
        defuse     = 1'b0;
        @(negedge clk);
        steps(2);
        reset = 1'b0;

        check_eq("rst_digits", 32'(digits), 32'h000);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_expired", 32'(expired), 32'd0);
        check_eq("rst_defused", 32'(defused), 32'd0);
        check_eq("rst_tick", 32'(sec_tick), 32'd0);
        check_eq("rst_warn", 32'(warn), 32'd0);

        // Level 0: 300 after two edges, first tick four cycles later.
        start_level(8'd0);
        check_eq("l0_digits", 32'(digits), 32'h300);
        check_eq("l0_running", 32'(running), 32'd1);
        steps(3);
        check_eq("l0_pre_tick", 32'(digits), 32'h300);
        check_eq("l0_pre_tick_pulse", 32'(sec_tick), 32'd0);
        step();
        check_eq("l0_tick_digits", 32'(digits), 32'h299);
        check_eq("l0_tick_pulse", 32'(sec_tick), 32'd1);
        step();
        check_eq("l0_tick_one_cycle", 32'(sec_tick), 32'd0);

        // Start while running is ignored.
        game_level = 8'd10;
        start      = 1'b1;
        step();
        start      = 1'b0;
        step();
        check_eq("run_start_ignored", 32'(digits), 32'h299);
        check_eq("run_start_running", 32'(running), 32'd1);

        // Reset mid-run at 173.
        reset = 1'b1;
        step();
        reset = 1'b0;
        start_level(8'd6);
        check_eq("l6_digits", 32'(digits), 32'h180);
        wait_digits("reach_173", 12'h173);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midrst_digits", 32'(digits), 32'h000);
        check_eq("midrst_running", 32'(running), 32'd0);
        check_eq("midrst_expired", 32'(expired), 32'd0);
        check_eq("midrst_defused", 32'(defused), 32'd0);
        check_eq("midrst_tick", 32'(sec_tick), 32'd0);
        step();
        check_eq("midrst_idle_hold", 32'(running), 32'd0);

        // Level clamps and defuse freeze.
        start_level(8'd10);
        check_eq("l10_digits", 32'(digits), 32'h100);
        defuse = 1'b1;
        step();
        defuse = 1'b0;
        check_eq("defuse_flag", 32'(defused), 32'd1);
        check_eq("defuse_digits", 32'(digits), 32'h100);

        // Restart from DEFUSED; strike together with tick at 120.
        start_level(8'd9);
        check_eq("l9_digits", 32'(digits), 32'h120);
        steps(3);
        strike = 1'b1;
        step();
        strike = 1'b0;
        check_eq("tick_strike_digits", 32'(digits), 32'h109);
        check_eq("tick_strike_pulse", 32'(sec_tick), 32'd1);

        // Strike at 045.
        defuse = 1'b1;
        step();
        defuse = 1'b0;
        start_level(8'd12);
        check_eq("l12_digits", 32'(digits), 32'h060);
        wait_digits("reach_045", 12'h045);
        strike = 1'b1;
        step();
        strike = 1'b0;
        check_eq("strike_045", 32'(digits), 32'h035);
        check_eq("strike_no_tick", 32'(sec_tick), 32'd0);

        // Warning at 009: two cycles high, two low when enabled.
        wait_digits("reach_009", 12'h009);
        for (int i = 0; i < 4; i++) begin
`ifdef BOMB_TIMER_WARN_EN
            check_eq("warn_blink", 32'(warn), (i < 2) ? 32'd1 : 32'd0);
`else
            check_eq("warn_off", 32'(warn), 32'd0);
`endif
            step();
        end
        check_eq("after_009", 32'(digits), 32'h008);

        // Strike at 007 saturates to 000 and expires on the same edge.
        wait_digits("reach_007", 12'h007);
        strike = 1'b1;
        step();
        strike = 1'b0;
        check_eq("strike_sat_digits", 32'(digits), 32'h000);
        check_eq("strike_sat_expired", 32'(expired), 32'd1);
        check_eq("strike_sat_running", 32'(running), 32'd0);
        check_eq("expired_warn", 32'(warn), 32'd0);
        strike = 1'b1;
        step();
        strike = 1'b0;
        check_eq("expired_strike_ignored", 32'(digits), 32'h000);
        check_eq("expired_stays", 32'(expired), 32'd1);
        start_level(8'd0);
        check_eq("restart_digits", 32'(digits), 32'h300);
        check_eq("restart_expired", 32'(expired), 32'd0);

        // Level 200 clamps to 030; defuse beats a tick at 001.
        reset = 1'b1;
        step();
        reset = 1'b0;
        start_level(8'd200);
        check_eq("l200_digits", 32'(digits), 32'h030);
        wait_digits("reach_001", 12'h001);
        steps(3);
        defuse = 1'b1;
        step();
        defuse = 1'b0;
        check_eq("defuse_tick_flag", 32'(defused), 32'd1);
        check_eq("defuse_tick_digits", 32'(digits), 32'h001);
        check_eq("defuse_tick_expired", 32'(expired), 32'd0);
        check_eq("defuse_tick_pulse", 32'(sec_tick), 32'd0);

        // Pause at 250 with prescaler at 2, strike while paused, resume.
        start_level(8'd2);
        check_eq("l2_digits", 32'(digits), 32'h260);
        wait_digits("reach_250", 12'h250);
        steps(2);
        pause = 1'b1;
        steps(10);
        check_eq("pause_hold", 32'(digits), 32'h250);
        check_eq("pause_running", 32'(running), 32'd0);
        strike = 1'b1;
        step();
        strike = 1'b0;
        check_eq("pause_strike", 32'(digits), 32'h240);
        steps(9);
        check_eq("pause_hold2", 32'(digits), 32'h240);
        pause = 1'b0;
        step();
        check_eq("resume_running", 32'(running), 32'd1);
        check_eq("resume_e1", 32'(digits), 32'h240);
        step();
        check_eq("resume_e2", 32'(digits), 32'h240);
        step();
        check_eq("resume_tick", 32'(digits), 32'h239);
        check_eq("resume_tick_pulse", 32'(sec_tick), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
